io_port_unit: RTL and testbench

IO_PORT_UNIT -- requirements
Module: io_port_unit

---
 rtl/io_port_unit_if.sv | 52 +++++
 rtl/io_port_unit.sv | 162 ++++++++++++++++
 tb/tb_io_port_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_unit_if.sv
//------------------------------------------------------------------------------
// io_port_unit_if
// Bus bundle between the datapath/external device side and io_port_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface io_port_unit_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2
);
  localparam int C_IN_SEL_W  = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int C_OUT_SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  // Input-channel side
  logic [NUM_IN*DATA_W-1:0]   in_data;
  logic [NUM_IN-1:0]          in_strobe;
  logic [C_IN_SEL_W-1:0]      in_sel;
  logic                       InPortout;
  logic [DATA_W-1:0]          BusMuxIn_InPort;
  logic [NUM_IN-1:0]          in_empty;
  logic [NUM_IN-1:0]          in_full;
  logic [NUM_IN-1:0]          in_overflow;

  // Output-channel side
  logic [C_OUT_SEL_W-1:0]     out_sel;
  logic                       OutPortin;
  logic [DATA_W-1:0]          BusMuxOut;
  logic [NUM_OUT*DATA_W-1:0]  OutPortdata;
  logic [NUM_OUT-1:0]         out_valid;
  logic [NUM_OUT-1:0]         out_overrun;
  logic [NUM_OUT-1:0]         out_ack;

  logic                       flag_clr;

  modport master (
    output in_data, in_strobe, in_sel, InPortout,
    output out_sel, OutPortin, BusMuxOut, out_ack, flag_clr,
    input  BusMuxIn_InPort, in_empty, in_full, in_overflow,
    input  OutPortdata, out_valid, out_overrun
  );

  modport slave (
    input  in_data, in_strobe, in_sel, InPortout,
    input  out_sel, OutPortin, BusMuxOut, out_ack, flag_clr,
    output BusMuxIn_InPort, in_empty, in_full, in_overflow,
    output OutPortdata, out_valid, out_overrun
  );
endinterface

`default_nettype wire

// File: rtl/io_port_unit.sv
//------------------------------------------------------------------------------
// io_port_unit
// Per-channel input FIFOs with a zero-latency read mux, and per-channel
// output registers with a valid/ack handshake and sticky error flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_port_unit #(
  parameter int DATA_W     = 32,
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic     clock,
  input  wire logic     clear,
  io_port_unit_if.slave bus
);

  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } out_state_t;

  logic [DATA_W-1:0] w_head [NUM_IN];
  logic [NUM_IN-1:0] w_nonempty;
  logic [DATA_W-1:0] w_rd_data;

  //--------------------------------------------------------------------------
  // Input channels
  //--------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
      logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
      logic [C_PTR_W-1:0] r_rptr;
      logic [C_PTR_W-1:0] r_wptr;
      logic [C_CNT_W-1:0] r_cnt;
      logic               r_ovf;
      logic               w_empty;
      logic               w_full;
      logic               w_pop;
      logic               w_push;
      logic               w_ovf_set;

      assign w_empty   = (r_cnt == '0);
      assign w_full    = (r_cnt == C_DEPTH);
      assign w_pop     = bus.InPortout && (int'(bus.in_sel) == k) && !w_empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      assign w_push    = bus.in_strobe[k] && (!w_full || w_pop);
      assign w_ovf_set = bus.in_strobe[k] && w_full && !w_pop;

      // Storage: no reset needed, reads are masked by the occupancy count
      always_ff @(posedge clock) begin
        if (w_push) begin
          r_mem[r_wptr] <= bus.in_data[k*DATA_W +: DATA_W];
        end
      end

      // Pointers, occupancy and sticky overflow flag
      always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
          r_rptr <= '0;
          r_wptr <= '0;
          r_cnt  <= '0;
          r_ovf  <= 1'b0;
        end else begin
          if (w_push) r_wptr <= r_wptr + C_PTR_W'(1);
          if (w_pop)  r_rptr <= r_rptr + C_PTR_W'(1);
          case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + C_CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - C_CNT_W'(1);
            default: r_cnt <= r_cnt;
          endcase
          if (w_ovf_set)         r_ovf <= 1'b1;
          else if (bus.flag_clr) r_ovf <= 1'b0;
        end
      end

      assign w_head[k]          = r_mem[r_rptr];
      assign w_nonempty[k]      = !w_empty;
      assign bus.in_empty[k]    = w_empty;
      assign bus.in_full[k]     = w_full;
      assign bus.in_overflow[k] = r_ovf;
    end
  endgenerate

  // Zero-latency read mux; an empty or out-of-range channel reads as zero
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ((int'(bus.in_sel) == k) && w_nonempty[k]) begin
        w_rd_data = w_head[k];
      end
    end
  end

  assign bus.BusMuxIn_InPort = w_rd_data;

  //--------------------------------------------------------------------------
  // Output channels
  //--------------------------------------------------------------------------
  generate
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      out_state_t        r_state;
      out_state_t        w_state_nxt;
      logic [DATA_W-1:0] r_data;
      logic              r_ovr;
      logic              w_load;
      logic              w_ack;
      logic              w_ovr_set;

      // An out-of-range out_sel never matches, so that write is dropped.
      assign w_load = bus.OutPortin && (int'(bus.out_sel) == j);
      assign w_ack  = bus.out_ack[j];

      // Next state; a reload acked in the same cycle is not an overrun
      always_comb begin
        w_state_nxt = r_state;
        w_ovr_set   = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_load) w_state_nxt = S_PENDING;
          end
          S_PENDING: begin
            if (w_load) begin
              w_state_nxt = S_PENDING;
              w_ovr_set   = !w_ack;
            end else if (w_ack) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end

      // State, data register and sticky overrun flag
      always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
          r_state <= S_IDLE;
          r_data  <= '0;
          r_ovr   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          if (w_load) r_data <= bus.BusMuxOut;
          if (w_ovr_set)         r_ovr <= 1'b1;
          else if (bus.flag_clr) r_ovr <= 1'b0;
        end
      end

      assign bus.OutPortdata[j*DATA_W +: DATA_W] = r_data;
      assign bus.out_valid[j]                    = (r_state == S_PENDING);
      assign bus.out_overrun[j]                  = r_ovr;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_io_port_unit.sv
//------------------------------------------------------------------------------
// tb_io_port_unit
// Directed and randomized checks of io_port_unit against a queue-based model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_port_unit;

  localparam int DW  = 32;
  localparam int NI  = 2;
  localparam int NO  = 2;
  localparam int DEP = 4;

  logic clock;
  logic clear;

  io_port_unit_if #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO)) bif ();

  io_port_unit #(
    .DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .FIFO_DEPTH(DEP)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per input channel, plain state per output channel
  logic [DW-1:0] q [NI][$];
  logic [NI-1:0] m_ovf;
  logic [DW-1:0] m_odata [NO];
  logic [NO-1:0] m_valid;
  logic [NO-1:0] m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) q[k].delete();
    m_ovf   = '0;
    m_valid = '0;
    m_ovr   = '0;
    for (int j = 0; j < NO; j++) m_odata[j] = '0;
  endtask

  task automatic idle();
    bif.in_data   = '0;
    bif.in_strobe = '0;
    bif.in_sel    = '0;
    bif.InPortout = 1'b0;
    bif.out_sel   = '0;
    bif.OutPortin = 1'b0;
    bif.BusMuxOut = '0;
    bif.out_ack   = '0;
    bif.flag_clr  = 1'b0;
  endtask

  // Apply one clock edge's worth of behaviour to the model
  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      bit pop, full, push, oset;
      pop  = bif.InPortout && (int'(bif.in_sel) == k) && (q[k].size() > 0);
      full = (q[k].size() == DEP);
      push = bif.in_strobe[k] && (!full || pop);
      oset = bif.in_strobe[k] && full && !pop;
      if (pop)  void'(q[k].pop_front());
      if (push) q[k].push_back(bif.in_data[k*DW +: DW]);
      if (oset) m_ovf[k] = 1'b1;
      else if (bif.flag_clr) m_ovf[k] = 1'b0;
    end
    for (int j = 0; j < NO; j++) begin
      bit load, oset;
      load = bif.OutPortin && (int'(bif.out_sel) == j);
      oset = load && m_valid[j] && !bif.out_ack[j];
      if (load) begin
        m_odata[j] = bif.BusMuxOut;
        m_valid[j] = 1'b1;
      end else if (bif.out_ack[j]) begin
        m_valid[j] = 1'b0;
      end
      if (oset) m_ovr[j] = 1'b1;
      else if (bif.flag_clr) m_ovr[j] = 1'b0;
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("in_empty[%0d]", k), 64'(bif.in_empty[k]), 64'(q[k].size() == 0));
      chk($sformatf("in_full[%0d]", k), 64'(bif.in_full[k]), 64'(q[k].size() == DEP));
      chk($sformatf("in_overflow[%0d]", k), 64'(bif.in_overflow[k]), 64'(m_ovf[k]));
    end
    for (int j = 0; j < NO; j++) begin
      chk($sformatf("out_valid[%0d]", j), 64'(bif.out_valid[j]), 64'(m_valid[j]));
      chk($sformatf("out_overrun[%0d]", j), 64'(bif.out_overrun[j]), 64'(m_ovr[j]));
      chk($sformatf("out_data[%0d]", j), 64'(bif.OutPortdata[j*DW +: DW]), 64'(m_odata[j]));
    end
  endtask

  // Inputs are already driven: check the read mux, take an edge, check state
  task automatic cycle();
    logic [DW-1:0] exp_rd;
    int s;
    #1;
    s = int'(bif.in_sel);
    exp_rd = '0;
    if (s < NI) begin
      if (q[s].size() > 0) exp_rd = q[s][0];
    end
    chk("rd_data", 64'(bif.BusMuxIn_InPort), 64'(exp_rd));
    @(posedge clock);
    model_update();
    #1;
    check_state();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_empty"}, 64'(bif.in_empty), 64'({NI{1'b1}}));
    chk({tag, "_full"}, 64'(bif.in_full), 64'd0);
    chk({tag, "_ovf"}, 64'(bif.in_overflow), 64'd0);
    chk({tag, "_rd"}, 64'(bif.BusMuxIn_InPort), 64'd0);
    chk({tag, "_valid"}, 64'(bif.out_valid), 64'd0);
    chk({tag, "_ovr"}, 64'(bif.out_overrun), 64'd0);
    chk({tag, "_odata"}, 64'(bif.OutPortdata), 64'd0);
  endtask

  initial begin
    idle();
    model_reset();
    clear = 1'b0;
    #2;
    check_reset_outputs("por");
    #10;
    clear = 1'b1;
    @(posedge clock);
    #1;

    // Single push then zero-latency pop on channel 0
    idle(); bif.in_strobe = 2'b01; bif.in_data[31:0] = 32'h12345678; cycle();
    idle(); bif.in_sel = 1'b0; bif.InPortout = 1'b1;
    #1; chk("push_pop_rd", 64'(bif.BusMuxIn_InPort), 64'h12345678);
    cycle();
    chk("push_pop_empty", 64'(bif.in_empty[0]), 64'd1);

    // Five strobes into a four-deep channel 1, then drain
    for (int i = 1; i <= 5; i++) begin
      idle(); bif.in_strobe = 2'b10; bif.in_data[63:32] = 32'(i); cycle();
    end
    chk("ovf_full", 64'(bif.in_full[1]), 64'd1);
    chk("ovf_flag", 64'(bif.in_overflow[1]), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(); bif.in_sel = 1'b1; bif.InPortout = 1'b1;
      #1; chk($sformatf("drain_%0d", i), 64'(bif.BusMuxIn_InPort), 64'(i));
      cycle();
    end
    chk("drain_ovf_sticky", 64'(bif.in_overflow[1]), 64'd1);
    idle(); bif.flag_clr = 1'b1; cycle();
    chk("ovf_cleared", 64'(bif.in_overflow[1]), 64'd0);

    // Full channel with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      idle(); bif.in_strobe = 2'b10; bif.in_data[63:32] = 32'h11 + 32'(i); cycle();
    end
    idle(); bif.in_sel = 1'b1; bif.InPortout = 1'b1;
    bif.in_strobe = 2'b10; bif.in_data[63:32] = 32'hAA;
    #1; chk("pp_oldest", 64'(bif.BusMuxIn_InPort), 64'h11);
    cycle();
    chk("pp_full", 64'(bif.in_full[1]), 64'd1);
    chk("pp_no_ovf", 64'(bif.in_overflow[1]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(); bif.in_sel = 1'b1; bif.InPortout = 1'b1; cycle();
    end
    chk("pp_last_empty", 64'(bif.in_empty[1]), 64'd1);

    // Output write and ack
    idle(); bif.out_sel = 1'b1; bif.OutPortin = 1'b1; bif.BusMuxOut = 32'hDEADBEEF; cycle();
    chk("out_data1", 64'(bif.OutPortdata[63:32]), 64'hDEADBEEF);
    chk("out_valid1", 64'(bif.out_valid[1]), 64'd1);
    idle(); bif.out_ack = 2'b10; cycle();
    chk("out_acked", 64'(bif.out_valid[1]), 64'd0);
    chk("out_retained", 64'(bif.OutPortdata[63:32]), 64'hDEADBEEF);

    // Overrun on channel 0, sticky until flag_clr
    idle(); bif.OutPortin = 1'b1; bif.BusMuxOut = 32'h1111; cycle();
    idle(); bif.OutPortin = 1'b1; bif.BusMuxOut = 32'h2222; cycle();
    idle(); cycle(); cycle();
    chk("ovr_set", 64'(bif.out_overrun[0]), 64'd1);
    chk("ovr_second", 64'(bif.OutPortdata[31:0]), 64'h2222);
    idle(); bif.flag_clr = 1'b1; cycle();
    chk("ovr_cleared", 64'(bif.out_overrun[0]), 64'd0);

    // Reload with same-cycle ack: stays pending, no overrun
    idle(); bif.OutPortin = 1'b1; bif.BusMuxOut = 32'h3333; bif.out_ack = 2'b01; cycle();
    chk("load_ack_valid", 64'(bif.out_valid[0]), 64'd1);
    chk("load_ack_no_ovr", 64'(bif.out_overrun[0]), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      idle();
      bif.in_strobe = 2'($urandom);
      bif.in_data   = {$urandom, $urandom};
      bif.in_sel    = 1'($urandom);
      bif.InPortout = ($urandom_range(0, 2) == 0);
      bif.out_sel   = 1'($urandom);
      bif.OutPortin = ($urandom_range(0, 2) == 0);
      bif.BusMuxOut = $urandom;
      bif.out_ack   = 2'($urandom);
      bif.flag_clr  = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Asynchronous reset mid-transfer with data buffered
    idle(); bif.in_strobe = 2'b11; bif.in_data = {32'hCAFE0001, 32'hCAFE0000};
    bif.OutPortin = 1'b1; bif.BusMuxOut = 32'h5A5A5A5A; cycle();
    idle(); bif.in_sel = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    idle(); bif.in_strobe = 2'b01; bif.in_data[31:0] = 32'h0BADF00D; cycle();
    idle(); bif.InPortout = 1'b1;
    #1; chk("post_rst_rd", 64'(bif.BusMuxIn_InPort), 64'h0BADF00D);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
